adc_scan_sched: RTL and testbench
=================================

ADC_SCAN_SCHED -- requirements
Module: adc_scan_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, 4096, max clk cycles waiting for adc_busy rise or for the next sample before abort.
REQ-002 Parameter PERIOD_W, 16, width of the scan-period counter.
REQ-003 clk  in  1  system clock; all logic rising-edge.
REQ-004 rst_l  in  1  reset, asynchronous, active-low.
REQ-005 cfg_start  in  1  one-cycle pulse: begin scanning.
REQ-006 cfg_stop  in  1  one-cycle pulse: stop after the current scan.
REQ-007 cfg_continuous  in  1  1 = rescan every cfg_period cycles; 0 = single scan.
REQ-008 cfg_period  in  PERIOD_W  cycles from one sync to the next in continuous mode.
REQ-009 cfg_en_mask  in  8  per-channel capture enable.
REQ-010 adc_sync  out  1  one-cycle scan trigger to the 8-channel ADC interface.
REQ-011 adc_busy  in  1  ADC interface is mid-scan.
REQ-012 adc_dvalid  in  1  one-cycle pulse: adc_ch/adc_data valid.
REQ-013 adc_ch  in  3  channel of the current sample.
REQ-014 adc_data  in  12  conversion result.
REQ-015 rd_req  in  1  host read request; rd_addr  in  3  channel to read.
REQ-016 rd_data  out  12  result; rd_valid  out  1  rd_data valid, fresh flag of that channel in rd_fresh  out  1.
REQ-017 scan_done  out  1  one-cycle pulse at end of a scan; scan_err  out  1  sticky timeout flag; active  out  1  scheduler not IDLE.

Function
REQ-018 States: IDLE, TRIG, WAIT_BUSY, SCAN, HOLD; active = (state != IDLE).
REQ-019 IDLE -> TRIG on cfg_start; cfg_start outside IDLE ignored.
REQ-020 TRIG: adc_sync = 1 for exactly one cycle, period counter loaded with cfg_period-1, go to WAIT_BUSY.
REQ-021 WAIT_BUSY: adc_busy = 1 -> SCAN; timeout counter reaching TIMEOUT_CYC -> scan_err set, go IDLE.
REQ-022 SCAN: each adc_dvalid with cfg_en_mask[adc_ch] = 1 writes adc_data into result[adc_ch] and sets fresh[adc_ch]; masked channels untouched.
REQ-023 SCAN: timeout counter clears on every adc_dvalid; reaching TIMEOUT_CYC sets scan_err, go IDLE, no scan_done.
REQ-024 SCAN ends on adc_busy falling (1 -> 0): scan_done pulses next cycle; go HOLD if cfg_continuous and no stop pending, else IDLE.
REQ-025 HOLD: period counter decrements each cycle from TRIG; at 0 -> TRIG; if the scan outlasted cfg_period, TRIG occurs the cycle after entering HOLD (no negative wrap).
REQ-026 cfg_period = 0 treated as 1.
REQ-027 cfg_stop sets a stop-pending bit in any non-IDLE state; HOLD with stop pending -> IDLE immediately; bit clears on entering IDLE.
REQ-028 Host read: rd_req in cycle N -> rd_data = result[rd_addr], rd_fresh = fresh[rd_addr], rd_valid = 1 in cycle N+1; rd_valid 0 otherwise; fresh[rd_addr] cleared by the read.
REQ-029 Simultaneous read and write of the same channel: rd_data returns the old value, fresh stays 1 (write wins).
REQ-030 cfg_en_mask, cfg_continuous sampled in TRIG and held for that scan; cfg_period sampled in TRIG.
REQ-031 scan_err clears only on cfg_start accepted in IDLE.

Reset
REQ-032 Asynchronous on rst_l low: state IDLE, adc_sync 0, scan_done 0, rd_valid 0, rd_data 0, rd_fresh 0, scan_err 0, all result 0, all fresh 0, counters 0, stop pending 0.
REQ-033 Reset mid-scan abandons the scan without scan_done; first cfg_start after release starts normally.

Structure
REQ-034 Shared package adc_pkg holds state encoding, ADC_CH_NUM = 8, ADC_DATA_W = 12.
REQ-035 One sub-module: adc_result_bank (8x12 register file + fresh bits, one write port, one registered read port).

Verification
REQ-036 cfg_start, single mode, mask 0xFF, model returns ch k data 0x100+k -> one adc_sync, scan_done once, reads return 0x100..0x107 with rd_fresh 1, re-read rd_fresh 0.
REQ-037 Continuous, cfg_period 500, scan 300 cycles -> adc_sync pulses exactly 500 cycles apart for 3 scans; cfg_stop mid-third scan -> scan_done then IDLE, no 4th sync.
REQ-038 Mask 0x05 -> only result[0], result[2] updated; others retain prior values, fresh 0.
REQ-039 adc_busy never rises -> scan_err 1 after TIMEOUT_CYC cycles, IDLE, no scan_done; next cfg_start clears scan_err.
REQ-040 rd_req on ch 3 same cycle as adc_dvalid ch 3 -> old value returned, fresh[3] 1 afterwards.
REQ-041 rst_l low during SCAN -> all outputs at reset values, no scan_done; cfg_start after release runs a full scan.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC scan scheduler: channel geometry and FSM encoding.
package adc_pkg;

  localparam int ADC_CH_NUM = 8;
  localparam int ADC_DATA_W = 12;
  localparam int ADC_CH_W   = $clog2(ADC_CH_NUM);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_SCAN      = 3'd3,
    ST_HOLD      = 3'd4
  } sched_state_t;

endpackage

// File: rtl/adc_result_bank.sv
// Per-channel result register file with fresh flags: one write port from the
// scan engine and one registered host read port that consumes the fresh flag.
module adc_result_bank
  import adc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  wr_en,
  input  logic [ADC_CH_W-1:0]   wr_ch,
  input  logic [ADC_DATA_W-1:0] wr_data,
  input  logic                  rd_req,
  input  logic [ADC_CH_W-1:0]   rd_addr,
  output logic [ADC_DATA_W-1:0] rd_data,
  output logic                  rd_fresh,
  output logic                  rd_valid
);

  logic [ADC_DATA_W-1:0] result_reg [ADC_CH_NUM];
  logic [ADC_CH_NUM-1:0] fresh_reg;

  // Storage update: a read clears the fresh flag, a write to the same channel
  // in the same cycle is applied last so the flag stays set.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < ADC_CH_NUM; i++) begin
        result_reg[i] <= '0;
      end
      fresh_reg <= '0;
    end else begin
      if (rd_req) begin
        fresh_reg[rd_addr] <= 1'b0;
      end
      if (wr_en) begin
        result_reg[wr_ch] <= wr_data;
        fresh_reg[wr_ch]  <= 1'b1;
      end
    end
  end

  // Registered read port: returns the pre-write contents one cycle after rd_req.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_data  <= '0;
      rd_fresh <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data  <= result_reg[rd_addr];
        rd_fresh <= fresh_reg[rd_addr];
      end
    end
  end

endmodule

// File: rtl/adc_scan_sched.sv
// Scan scheduler for an 8-channel ADC: triggers single or periodic scans,
// captures enabled channels into a result bank, and supervises with timeouts.
module adc_scan_sched
  import adc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int PERIOD_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic                  cfg_continuous,
  input  logic [PERIOD_W-1:0]   cfg_period,
  input  logic [ADC_CH_NUM-1:0] cfg_en_mask,
  output logic                  adc_sync,
  input  logic                  adc_busy,
  input  logic                  adc_dvalid,
  input  logic [ADC_CH_W-1:0]   adc_ch,
  input  logic [ADC_DATA_W-1:0] adc_data,
  input  logic                  rd_req,
  input  logic [ADC_CH_W-1:0]   rd_addr,
  output logic [ADC_DATA_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_fresh,
  output logic                  scan_done,
  output logic                  scan_err,
  output logic                  active
);

  localparam int TOUT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYC - 1);

  sched_state_t          state_reg, state_next;
  logic [PERIOD_W-1:0]   period_cnt_reg, period_cnt_next;
  logic [TOUT_W-1:0]     tout_cnt_reg, tout_cnt_next;
  logic [ADC_CH_NUM-1:0] mask_reg, mask_next;
  logic                  cont_reg, cont_next;
  logic                  stop_pend_reg, stop_pend_next;
  logic                  scan_err_reg, scan_err_next;
  logic                  scan_done_reg, scan_done_next;
  logic                  busy_d_reg;
  logic                  busy_fall;
  logic                  stop_req;
  logic                  wr_en;

  assign busy_fall = busy_d_reg & ~adc_busy;
  assign stop_req  = stop_pend_reg | cfg_stop;

  // State and per-scan context registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg      <= ST_IDLE;
      period_cnt_reg <= '0;
      tout_cnt_reg   <= '0;
      mask_reg       <= '0;
      cont_reg       <= 1'b0;
      stop_pend_reg  <= 1'b0;
      scan_err_reg   <= 1'b0;
      scan_done_reg  <= 1'b0;
      busy_d_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      period_cnt_reg <= period_cnt_next;
      tout_cnt_reg   <= tout_cnt_next;
      mask_reg       <= mask_next;
      cont_reg       <= cont_next;
      stop_pend_reg  <= stop_pend_next;
      scan_err_reg   <= scan_err_next;
      scan_done_reg  <= scan_done_next;
      busy_d_reg     <= adc_busy;
    end
  end

  // Next-state logic: the period counter free-runs down from TRIG and saturates
  // at zero, so an overlong scan retriggers right after entering HOLD.
  always_comb begin
    state_next      = state_reg;
    period_cnt_next = (period_cnt_reg != '0) ? period_cnt_reg - PERIOD_W'(1) : '0;
    tout_cnt_next   = tout_cnt_reg;
    mask_next       = mask_reg;
    cont_next       = cont_reg;
    stop_pend_next  = stop_pend_reg | (cfg_stop && (state_reg != ST_IDLE));
    scan_err_next   = scan_err_reg;
    scan_done_next  = 1'b0;
    wr_en           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (cfg_start) begin
          state_next    = ST_TRIG;
          scan_err_next = 1'b0;
        end
      end
      ST_TRIG: begin
        // A zero period behaves like a period of one.
        period_cnt_next = (cfg_period == '0) ? '0 : cfg_period - PERIOD_W'(1);
        tout_cnt_next   = '0;
        mask_next       = cfg_en_mask;
        cont_next       = cfg_continuous;
        state_next      = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (adc_busy) begin
          tout_cnt_next = '0;
          state_next    = ST_SCAN;
        end else if (tout_cnt_reg == TOUT_LAST) begin
          scan_err_next = 1'b1;
          state_next    = ST_IDLE;
        end else begin
          tout_cnt_next = tout_cnt_reg + 1'b1;
        end
      end
      ST_SCAN: begin
        wr_en = adc_dvalid && mask_reg[adc_ch];
        if (busy_fall) begin
          scan_done_next = 1'b1;
          state_next     = (cont_reg && !stop_req) ? ST_HOLD : ST_IDLE;
        end else if (adc_dvalid) begin
          tout_cnt_next = '0;
        end else if (tout_cnt_reg == TOUT_LAST) begin
          scan_err_next = 1'b1;
          state_next    = ST_IDLE;
        end else begin
          tout_cnt_next = tout_cnt_reg + 1'b1;
        end
      end
      ST_HOLD: begin
        if (stop_req) begin
          state_next = ST_IDLE;
        end else if (period_cnt_reg <= PERIOD_W'(1)) begin
          state_next = ST_TRIG;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (state_next == ST_IDLE) begin
      stop_pend_next = 1'b0;
    end
  end

  assign adc_sync  = (state_reg == ST_TRIG);
  assign active    = (state_reg != ST_IDLE);
  assign scan_done = scan_done_reg;
  assign scan_err  = scan_err_reg;

  adc_result_bank u_bank (
    .clk      (clk),
    .rst_l    (rst_l),
    .wr_en    (wr_en),
    .wr_ch    (adc_ch),
    .wr_data  (adc_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_fresh (rd_fresh),
    .rd_valid (rd_valid)
  );

endmodule

// File: tb/tb_adc_scan_sched.sv
// Scoreboard bench for adc_scan_sched: a reactive ADC model plus a channel-level
// reference of results/fresh flags; a monitor pops expectations on rd_valid/scan_done.
module tb_adc_scan_sched;

  localparam int TO = 256;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_stop = 1'b0;
  logic          cfg_continuous = 1'b0;
  logic [PW-1:0] cfg_period = '0;
  logic [7:0]    cfg_en_mask = 8'hFF;
  logic          adc_sync;
  logic          adc_busy = 1'b0;
  logic          adc_dvalid = 1'b0;
  logic [2:0]    adc_ch = '0;
  logic [11:0]   adc_data = '0;
  logic          rd_req = 1'b0;
  logic [2:0]    rd_addr = '0;
  logic [11:0]   rd_data;
  logic          rd_valid;
  logic          rd_fresh;
  logic          scan_done;
  logic          scan_err;
  logic          active;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sync_cnt = 0;
  int done_seen = 0;
  logic [12:0] rd_q[$];
  int          done_q[$];
  int          sync_log[$];
  logic [12:0] mon_exp;
  int          mon_done;

  logic [11:0] ref_result [8];
  logic [7:0]  ref_fresh;
  logic [7:0]  scan_mask = '0;
  logic        wr_hit;
  bit          adc_dead = 1'b0;
  bit          data_fixed = 1'b0;
  int          scan_len = 40;

  adc_scan_sched #(.TIMEOUT_CYC(TO), .PERIOD_W(PW)) dut (
    .clk(clk), .rst_l(rst_l), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_continuous(cfg_continuous), .cfg_period(cfg_period), .cfg_en_mask(cfg_en_mask),
    .adc_sync(adc_sync), .adc_busy(adc_busy), .adc_dvalid(adc_dvalid), .adc_ch(adc_ch),
    .adc_data(adc_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_fresh(rd_fresh), .scan_done(scan_done), .scan_err(scan_err),
    .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: per-channel results and fresh flags, updated at each edge.
  assign wr_hit = adc_dvalid && scan_mask[adc_ch];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_l) begin
      for (int i = 0; i < 8; i++) ref_result[i] <= '0;
      ref_fresh <= '0;
      rd_q.delete();
      done_q.delete();
    end else begin
      if (rd_req) begin
        rd_q.push_back({ref_result[rd_addr], ref_fresh[rd_addr]});
        if (!(wr_hit && adc_ch == rd_addr)) ref_fresh[rd_addr] <= 1'b0;
      end
      if (wr_hit) begin
        ref_result[adc_ch] <= adc_data;
        ref_fresh[adc_ch]  <= 1'b1;
      end
    end
  end

  // Monitor: one line per completed read or scan, compared against the queues.
  always @(negedge clk) begin
    if (rst_l) begin
      if (adc_sync) begin
        sync_cnt++;
        sync_log.push_back(cyc);
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected: rd_valid=1 with no read pending");
        end else begin
          mon_exp = rd_q.pop_front();
          $display("read  cyc=%0d data=0x%03h fresh=%0d", cyc, rd_data, rd_fresh);
          check("rd_data", int'(rd_data), int'(mon_exp[12:1]));
          check("rd_fresh", int'(rd_fresh), int'(mon_exp[0]));
        end
      end
      if (scan_done) begin
        done_seen++;
        $display("scan_done cyc=%0d", cyc);
        if (done_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected: scan_done=1 with no scan completed");
        end else begin
          mon_done = done_q.pop_front();
          check("scan_done_cycle", cyc, mon_done);
        end
      end
    end
  end

  // ADC interface model: one scan of scan_len busy cycles, channels 0..7 spread inside.
  task automatic run_scan();
    int gap;
    int stride;
    int k;
    scan_mask = cfg_en_mask;
    if (adc_dead) return;
    gap = $urandom_range(0, 3);
    for (int g = 0; g <= gap; g++) begin
      @(posedge clk); #1;
      if (!rst_l) return;
    end
    adc_busy = 1'b1;
    stride = (scan_len - 2) / 8;
    k = 0;
    for (int c = 1; c <= scan_len; c++) begin
      @(posedge clk); #1;
      if (!rst_l) begin
        adc_busy = 1'b0;
        adc_dvalid = 1'b0;
        return;
      end
      adc_dvalid = 1'b0;
      if (c == scan_len) begin
        adc_busy = 1'b0;
        done_q.push_back(cyc + 1);
      end else if (k < 8 && c == 1 + k * stride) begin
        adc_dvalid = 1'b1;
        adc_ch = 3'(k);
        adc_data = data_fixed ? 12'(256 + k) : 12'($urandom_range(0, 4095));
        k++;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_l && adc_sync) run_scan();
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1; tick(1); cfg_start = 1'b0;
  endtask

  task automatic pulse_stop();
    cfg_stop = 1'b1; tick(1); cfg_stop = 1'b0;
  endtask

  task automatic do_read(input int a);
    rd_req = 1'b1; rd_addr = 3'(a); tick(1); rd_req = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) do_read(a);
    tick(2);
  endtask

  task automatic random_reads(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) do_read($urandom_range(0, 7));
      else tick(1);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (active && n < budget) begin tick(1); n++; end
    checks++;
    if (active) begin
      failures++;
      $display("FAIL %s: active=1 after %0d cycles, required 0", name, budget);
    end
  endtask

  task automatic read_on_dvalid(input int ch, input int budget);
    int n = 0;
    bit hit = 1'b0;
    while (n < budget && !hit) begin
      @(negedge clk);
      if (adc_dvalid && adc_ch == 3'(ch)) hit = 1'b1;
      else n++;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL collide_wait: no sample on ch %0d within %0d cycles", ch, budget);
      tick(1);
      return;
    end
    rd_req = 1'b1; rd_addr = 3'(ch);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_adc_sync"}, int'(adc_sync), 0);
    check({tag, "_scan_done"}, int'(scan_done), 0);
    check({tag, "_rd_valid"}, int'(rd_valid), 0);
    check({tag, "_rd_data"}, int'(rd_data), 0);
    check({tag, "_rd_fresh"}, int'(rd_fresh), 0);
    check({tag, "_scan_err"}, int'(scan_err), 0);
    check({tag, "_active"}, int'(active), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int d0;
    int l0;
    int n;
    tick(3);
    check_reset_outputs("rst");
    rst_l = 1'b1;
    tick(2);

    // Single scan, all channels, known data; then re-read for cleared fresh.
    data_fixed = 1'b1; scan_len = 40; cfg_en_mask = 8'hFF; cfg_continuous = 1'b0; cfg_period = 16'd100;
    s0 = sync_cnt; d0 = done_seen;
    pulse_start();
    wait_idle("t1_idle", 400);
    tick(5);
    check("t1_sync_count", sync_cnt - s0, 1);
    check("t1_done_count", done_seen - d0, 1);
    read_all();
    read_all();

    // Partial mask with random data: only ch0 and ch2 change.
    data_fixed = 1'b0; cfg_en_mask = 8'h05;
    pulse_start();
    wait_idle("t2_idle", 400);
    read_all();

    // Host read colliding with a write to the same channel.
    cfg_en_mask = 8'hFF; scan_len = 80;
    pulse_start();
    read_on_dvalid(3, 200);
    wait_idle("t3_idle", 400);
    do_read(3);
    do_read(3);
    tick(2);

    // Continuous mode, period 500, 300-cycle scans, stop during the third scan.
    cfg_continuous = 1'b1; cfg_period = 16'd500; scan_len = 300;
    cfg_en_mask = 8'($urandom_range(1, 255));
    s0 = sync_cnt; d0 = done_seen; l0 = sync_log.size();
    pulse_start();
    n = 0;
    while (sync_cnt - s0 < 3 && n < 1600) begin
      if ($urandom_range(0, 3) == 0) do_read($urandom_range(0, 7));
      else tick(1);
      n++;
    end
    check("t4_third_sync_seen", int'(sync_cnt - s0 >= 3), 1);
    random_reads(150);
    pulse_stop();
    wait_idle("t4_idle", 600);
    tick(400);
    check("t4_sync_count", sync_cnt - s0, 3);
    check("t4_done_count", done_seen - d0, 3);
    if (sync_log.size() >= l0 + 3) begin
      check("t4_period_1", sync_log[l0 + 1] - sync_log[l0], 500);
      check("t4_period_2", sync_log[l0 + 2] - sync_log[l0 + 1], 500);
    end
    read_all();

    // ADC never goes busy: timeout, error flag, then cleared by the next start.
    cfg_continuous = 1'b0; adc_dead = 1'b1;
    d0 = done_seen;
    pulse_start();
    n = 0;
    while (!scan_err && n < TO + 50) begin tick(1); n++; end
    checks++;
    if (n < TO || n > TO + 2) begin
      failures++;
      $display("FAIL t5_timeout_latency: got %0d cycles required %0d..%0d", n, TO, TO + 2);
    end
    check("t5_scan_err", int'(scan_err), 1);
    check("t5_active", int'(active), 0);
    tick(3);
    check("t5_no_done", done_seen - d0, 0);
    adc_dead = 1'b0; scan_len = 40;
    pulse_start();
    check("t5_err_cleared", int'(scan_err), 0);
    wait_idle("t5_idle", 400);
    tick(3);
    check("t5_done_after_clear", done_seen - d0, 1);

    // Reset in the middle of a scan, then a full scan afterwards.
    cfg_en_mask = 8'hFF; scan_len = 80;
    d0 = done_seen;
    pulse_start();
    tick(30);
    #2;
    rst_l = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick(3);
    rst_l = 1'b1;
    tick(3);
    check("t6_no_done", done_seen - d0, 0);
    do_read(0);
    do_read(5);
    tick(2);
    pulse_start();
    wait_idle("t6_idle", 400);
    tick(3);
    check("t6_done_after_reset", done_seen - d0, 1);
    read_all();

    tick(5);
    check("rd_queue_drained", rd_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
